// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: chained valid/ready register stages, each with a main and a skid slot.
// Define PIPE_SKID_FLUSH_ZERO_EN to also zero all payload registers on flush.
module pipe_skid_stage #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 1,
  parameter int CW     = $clog2(2*STAGES+1)
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CW-1:0]    occupancy
);
  logic [STAGES-1:0] valid_m, valid_s;
  logic [STAGES-1:0][WIDTH-1:0] data_m, data_s;
  logic [STAGES-1:0] up_valid, dn_ready, take, push;
  logic [STAGES-1:0][WIDTH-1:0] up_data;
  for (genvar k = 0; k < STAGES; k++) begin : g_link
    if (k == 0) begin : g_head
      assign up_valid[k] = in_valid;
      assign up_data[k]  = in_data;
    end else begin : g_mid
      assign up_valid[k] = valid_m[k-1];
      assign up_data[k]  = data_m[k-1];
    end
    if (k == STAGES-1) begin : g_tail
      assign dn_ready[k] = out_ready;
    end else begin : g_next
      assign dn_ready[k] = !valid_s[k+1];
    end
  end
  // a stage only accepts while its skid slot is free, so ready is always a flop output
  assign take      = valid_m & dn_ready;
  assign push      = up_valid & ~valid_s;
  assign in_ready  = !valid_s[0];
  assign out_valid = valid_m[STAGES-1];
  assign out_data  = data_m[STAGES-1];
  assign occupancy = CW'($countones({valid_m, valid_s}));
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_m <= '0;
      valid_s <= '0;
      data_m  <= '0;
      data_s  <= '0;
    end else if (flush) begin
      valid_m <= '0;
      valid_s <= '0;
`ifdef PIPE_SKID_FLUSH_ZERO_EN
      data_m  <= '0;
      data_s  <= '0;
`endif
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (take[i] && valid_s[i]) begin
          data_m[i]  <= data_s[i];
          valid_s[i] <= 1'b0;
        end else if (push[i] && (take[i] || !valid_m[i])) begin
          data_m[i]  <= up_data[i];
          valid_m[i] <= 1'b1;
        end else if (push[i]) begin
          data_s[i]  <= up_data[i];
          valid_s[i] <= 1'b1;
        end else if (take[i]) begin
          valid_m[i] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: directed and scoreboard checks of pipe_skid_stage with STAGES=1 and STAGES=2.
module tb_pipe_skid_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  logic s1_flush = 0, s1_in_valid = 0, s1_out_ready = 0;
  logic [31:0] s1_in_data = '0;
  logic s1_in_ready, s1_out_valid;
  logic [31:0] s1_out_data;
  logic [1:0] s1_occupancy;
  logic s2_flush = 0, s2_in_valid = 0, s2_out_ready = 0;
  logic [31:0] s2_in_data = '0;
  logic s2_in_ready, s2_out_valid;
  logic [31:0] s2_out_data;
  logic [2:0] s2_occupancy;

  always #5 clk = ~clk;

  pipe_skid_stage #(.WIDTH(32), .STAGES(1)) u_s1 (
    .clk(clk), .reset(reset), .flush(s1_flush), .in_valid(s1_in_valid), .in_data(s1_in_data),
    .in_ready(s1_in_ready), .out_valid(s1_out_valid), .out_data(s1_out_data),
    .out_ready(s1_out_ready), .occupancy(s1_occupancy)
  );

  pipe_skid_stage #(.WIDTH(32), .STAGES(2)) u_s2 (
    .clk(clk), .reset(reset), .flush(s2_flush), .in_valid(s2_in_valid), .in_data(s2_in_data),
    .in_ready(s2_in_ready), .out_valid(s2_out_valid), .out_data(s2_out_data),
    .out_ready(s2_out_ready), .occupancy(s2_occupancy)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({s1_out_valid, s1_in_ready, s1_occupancy, s1_out_data} !== {1'b0, 1'b1, 2'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_s1: valid/ready/occ/data got %b/%b/%0d/%h want 0/1/0/0", s1_out_valid, s1_in_ready, s1_occupancy, s1_out_data);
    end
    n_tests++;
    if ({s2_out_valid, s2_in_ready, s2_occupancy, s2_out_data} !== {1'b0, 1'b1, 3'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_s2: valid/ready/occ/data got %b/%b/%0d/%h want 0/1/0/0", s2_out_valid, s2_in_ready, s2_occupancy, s2_out_data);
    end
    s1_in_valid = 1'b1;
    s1_in_data  = 32'hDEAD;
    tick();
    n_tests++;
    if ({s1_out_valid, s1_occupancy} !== {1'b0, 2'd0}) begin
      n_fail++;
      $display("FAIL reset_hold: valid/occ got %b/%0d want 0/0", s1_out_valid, s1_occupancy);
    end
    s1_in_valid = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_stream();
    logic [31:0] d [3] = '{32'h11, 32'h22, 32'h33};
    s1_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s1_in_valid = (i < 3);
      s1_in_data  = (i < 3) ? d[i] : 32'h0;
      tick();
      n_tests++;
      if (i < 3) begin
        if ({s1_out_valid, s1_out_data, s1_in_ready, s1_occupancy} !== {1'b1, d[i], 1'b1, 2'd1}) begin
          n_fail++;
          $display("FAIL stream_%0d: valid/data/ready/occ got %b/%h/%b/%0d want 1/%h/1/1", i, s1_out_valid, s1_out_data, s1_in_ready, s1_occupancy, d[i]);
        end
      end else if ({s1_out_valid, s1_occupancy} !== {1'b0, 2'd0}) begin
        n_fail++;
        $display("FAIL stream_end: valid/occ got %b/%0d want 0/0", s1_out_valid, s1_occupancy);
      end
    end
  endtask

  task automatic test_backpressure();
    s1_out_ready = 1'b0;
    s1_in_valid  = 1'b1;
    s1_in_data   = 32'hA;
    tick();
    n_tests++;
    if ({s1_out_valid, s1_out_data, s1_in_ready, s1_occupancy} !== {1'b1, 32'hA, 1'b1, 2'd1}) begin
      n_fail++;
      $display("FAIL bp_first: valid/data/ready/occ got %b/%h/%b/%0d want 1/a/1/1", s1_out_valid, s1_out_data, s1_in_ready, s1_occupancy);
    end
    s1_in_data = 32'hB;
    tick();
    n_tests++;
    if ({s1_out_data, s1_in_ready, s1_occupancy} !== {32'hA, 1'b0, 2'd2}) begin
      n_fail++;
      $display("FAIL bp_full: data/ready/occ got %h/%b/%0d want a/0/2", s1_out_data, s1_in_ready, s1_occupancy);
    end
    s1_in_data = 32'hC;
    tick();
    n_tests++;
    if ({s1_out_data, s1_in_ready, s1_occupancy} !== {32'hA, 1'b0, 2'd2}) begin
      n_fail++;
      $display("FAIL bp_hold: data/ready/occ got %h/%b/%0d want a/0/2", s1_out_data, s1_in_ready, s1_occupancy);
    end
    s1_out_ready = 1'b1;
    tick();
    n_tests++;
    if ({s1_out_valid, s1_out_data, s1_in_ready, s1_occupancy} !== {1'b1, 32'hB, 1'b1, 2'd1}) begin
      n_fail++;
      $display("FAIL bp_drain_b: valid/data/ready/occ got %b/%h/%b/%0d want 1/b/1/1", s1_out_valid, s1_out_data, s1_in_ready, s1_occupancy);
    end
    tick();
    n_tests++;
    if ({s1_out_valid, s1_out_data, s1_occupancy} !== {1'b1, 32'hC, 2'd1}) begin
      n_fail++;
      $display("FAIL bp_drain_c: valid/data/occ got %b/%h/%0d want 1/c/1", s1_out_valid, s1_out_data, s1_occupancy);
    end
    s1_in_valid = 1'b0;
    tick();
    n_tests++;
    if ({s1_out_valid, s1_occupancy} !== {1'b0, 2'd0}) begin
      n_fail++;
      $display("FAIL bp_empty: valid/occ got %b/%0d want 0/0", s1_out_valid, s1_occupancy);
    end
  endtask

  task automatic test_two_stage();
    int nxt = 1;
    int acc = 0;
    int expv = 1;
    s2_out_ready = 1'b0;
    s2_in_valid  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s2_in_data = 32'(nxt);
      if (s2_in_ready) begin
        acc++;
        nxt++;
      end
      tick();
    end
    n_tests++;
    if (acc != 4 || {s2_occupancy, s2_in_ready, s2_out_valid, s2_out_data} !== {3'd4, 1'b0, 1'b1, 32'd1}) begin
      n_fail++;
      $display("FAIL s2_fill: acc/occ/ready/valid/data got %0d/%0d/%b/%b/%h want 4/4/0/1/1", acc, s2_occupancy, s2_in_ready, s2_out_valid, s2_out_data);
    end
    s2_out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      s2_in_valid = (nxt <= 6);
      s2_in_data  = 32'(nxt);
      if (s2_out_valid) begin
        n_tests++;
        if (s2_out_data !== 32'(expv)) begin
          n_fail++;
          $display("FAIL s2_order: got %h want %h", s2_out_data, 32'(expv));
        end
        expv++;
      end
      if (s2_in_valid && s2_in_ready) nxt++;
      tick();
    end
    s2_in_valid = 1'b0;
    n_tests++;
    if (expv != 7 || s2_occupancy !== 3'd0) begin
      n_fail++;
      $display("FAIL s2_drain: outputs/occ got %0d/%0d want 6/0", expv - 1, s2_occupancy);
    end
  endtask

  task automatic test_latency();
    s2_out_ready = 1'b1;
    s2_in_valid  = 1'b1;
    s2_in_data   = 32'h99;
    tick();
    s2_in_valid = 1'b0;
    n_tests++;
    if ({s2_out_valid, s2_occupancy} !== {1'b0, 3'd1}) begin
      n_fail++;
      $display("FAIL lat_mid: valid/occ got %b/%0d want 0/1", s2_out_valid, s2_occupancy);
    end
    tick();
    n_tests++;
    if ({s2_out_valid, s2_out_data} !== {1'b1, 32'h99}) begin
      n_fail++;
      $display("FAIL lat_out: valid/data got %b/%h want 1/99", s2_out_valid, s2_out_data);
    end
    tick();
    n_tests++;
    if ({s2_out_valid, s2_occupancy} !== {1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL lat_empty: valid/occ got %b/%0d want 0/0", s2_out_valid, s2_occupancy);
    end
  endtask

  task automatic test_flush();
    s1_out_ready = 1'b0;
    s1_in_valid  = 1'b1;
    s1_in_data   = 32'hA1;
    tick();
    s1_in_data = 32'hB2;
    tick();
    n_tests++;
    if (s1_occupancy !== 2'd2) begin
      n_fail++;
      $display("FAIL flush_fill: occ got %0d want 2", s1_occupancy);
    end
    s1_flush   = 1'b1;
    s1_in_data = 32'h55;
    tick();
    s1_flush    = 1'b0;
    s1_in_valid = 1'b0;
    n_tests++;
    if ({s1_out_valid, s1_occupancy, s1_in_ready} !== {1'b0, 2'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL flush_clear: valid/occ/ready got %b/%0d/%b want 0/0/1", s1_out_valid, s1_occupancy, s1_in_ready);
    end
`ifdef PIPE_SKID_FLUSH_ZERO_EN
    n_tests++;
    if (s1_out_data !== 32'h0) begin
      n_fail++;
      $display("FAIL flush_zero: data got %h want 0", s1_out_data);
    end
`endif
    s1_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (s1_out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_no_55: valid got %b data %h want 0", s1_out_valid, s1_out_data);
      end
    end
  endtask

  task automatic test_async_reset();
    s1_out_ready = 1'b0;
    s1_in_valid  = 1'b1;
    s1_in_data   = 32'hC1;
    tick();
    s1_in_data = 32'hC2;
    tick();
    n_tests++;
    if (s1_occupancy !== 2'd2) begin
      n_fail++;
      $display("FAIL areset_fill: occ got %0d want 2", s1_occupancy);
    end
    #2 reset = 1'b0;
    s1_in_valid = 1'b0;
    #1;
    n_tests++;
    if ({s1_out_valid, s1_occupancy, s1_in_ready} !== {1'b0, 2'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL areset_now: valid/occ/ready got %b/%0d/%b want 0/0/1", s1_out_valid, s1_occupancy, s1_in_ready);
    end
    @(negedge clk);
    reset        = 1'b1;
    s1_out_ready = 1'b1;
    s1_in_valid  = 1'b1;
    s1_in_data   = 32'h77;
    tick();
    s1_in_valid = 1'b0;
    n_tests++;
    if ({s1_out_valid, s1_out_data, s1_occupancy} !== {1'b1, 32'h77, 2'd1}) begin
      n_fail++;
      $display("FAIL areset_77: valid/data/occ got %b/%h/%0d want 1/77/1", s1_out_valid, s1_out_data, s1_occupancy);
    end
    tick();
    n_tests++;
    if ({s1_out_valid, s1_occupancy} !== {1'b0, 2'd0}) begin
      n_fail++;
      $display("FAIL areset_only77: valid/occ got %b/%0d want 0/0", s1_out_valid, s1_occupancy);
    end
  endtask

  task automatic test_random();
    logic [31:0] q1 [$];
    logic [31:0] q2 [$];
    for (int c = 0; c < 10000; c++) begin
      s1_in_valid  = 1'($urandom_range(0, 1));
      s1_in_data   = $urandom;
      s1_out_ready = ($urandom_range(0, 2) != 0);
      s1_flush     = ($urandom_range(0, 63) == 0);
      s2_in_valid  = ($urandom_range(0, 3) != 0);
      s2_in_data   = $urandom;
      s2_out_ready = 1'($urandom_range(0, 1));
      s2_flush     = ($urandom_range(0, 63) == 0);
      n_tests++;
      if (s1_occupancy !== 2'(q1.size())) begin
        n_fail++;
        if (n_fail < 20) $display("FAIL rnd_occ_s1 cycle %0d: got %0d want %0d", c, s1_occupancy, q1.size());
      end
      n_tests++;
      if (s2_occupancy !== 3'(q2.size())) begin
        n_fail++;
        if (n_fail < 20) $display("FAIL rnd_occ_s2 cycle %0d: got %0d want %0d", c, s2_occupancy, q2.size());
      end
      if (s1_out_valid && s1_out_ready) begin
        n_tests++;
        if (q1.size() == 0 || s1_out_data !== q1[0]) begin
          n_fail++;
          if (n_fail < 20) $display("FAIL rnd_data_s1 cycle %0d: got %h want %h (depth %0d)", c, s1_out_data, (q1.size() != 0) ? q1[0] : 32'h0, q1.size());
        end
        if (q1.size() != 0) void'(q1.pop_front());
      end
      if (s2_out_valid && s2_out_ready) begin
        n_tests++;
        if (q2.size() == 0 || s2_out_data !== q2[0]) begin
          n_fail++;
          if (n_fail < 20) $display("FAIL rnd_data_s2 cycle %0d: got %h want %h (depth %0d)", c, s2_out_data, (q2.size() != 0) ? q2[0] : 32'h0, q2.size());
        end
        if (q2.size() != 0) void'(q2.pop_front());
      end
      if (s1_flush) q1.delete();
      else if (s1_in_valid && s1_in_ready) q1.push_back(s1_in_data);
      if (s2_flush) q2.delete();
      else if (s2_in_valid && s2_in_ready) q2.push_back(s2_in_data);
      tick();
    end
    s1_in_valid = 1'b0;
    s2_in_valid = 1'b0;
    s1_flush    = 1'b0;
    s2_flush    = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_two_stage();
    test_latency();
    test_flush();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
